// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - Sequenced, stallable fetch/next-PC controller for the MIPS core.
// Optional MIPS branch delay slot is enabled by defining PC_DELAY_SLOT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             im_req,
  output logic [IM_AW-1:0] im_addr,
  input  logic             im_ack,
  output logic             ir_valid,
  input  logic             exec_done,
  input  logic             npc_sel,
  input  logic             alu_zero,
  input  logic             is_jump,
  input  logic [15:0]      imm16,
  input  logic [25:0]      imm26,
  input  logic             stall,
  output logic [31:0]      pc,
  output logic [1:0]       state
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_FETCH = 2'd1;
  localparam logic [1:0]  S_EXEC  = 2'd2;
  localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ir_valid_q, ir_valid_d;
  logic        commit;
  logic        taken;
  logic [31:0] p4, bt, jt, target;

`ifdef PC_DELAY_SLOT_EN
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_pc_q, pend_pc_d;
`endif

  assign commit = (state_q == S_EXEC) & exec_done & ~stall;

  always_comb begin
    p4     = pc_q + 32'd4;
    bt     = p4 + {{14{imm16[15]}}, imm16, 2'b00};
    jt     = {p4[31:28], imm26, 2'b00};
    taken  = is_jump | (npc_sel & alu_zero);
    target = is_jump ? jt : bt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (im_ack) state_d = S_EXEC;
      S_EXEC:  if (commit) state_d = S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    im_req   = (state_q == S_FETCH);
    im_addr  = pc_q[IM_AW+1:2];
    ir_valid = ir_valid_q;
    pc       = pc_q;
    state    = state_q;
  end

  always_comb begin
    pc_d       = pc_q;
    ir_valid_d = (state_q == S_FETCH) & im_ack;
`ifdef PC_DELAY_SLOT_EN
    pend_v_d  = pend_v_q;
    pend_pc_d = pend_pc_q;
    // The delay-slot instruction always falls through to the stored target.
    if (commit) begin
      if (pend_v_q) begin
        pc_d     = pend_pc_q;
        pend_v_d = 1'b0;
      end else begin
        pc_d = p4;
        if (taken) begin
          pend_pc_d = target;
          pend_v_d  = 1'b1;
        end
      end
    end
`else
    if (commit) begin
      pc_d = taken ? target : p4;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC_W;
      ir_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

`ifdef PC_DELAY_SLOT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_v_q  <= 1'b0;
      pend_pc_q <= 32'd0;
    end else begin
      pend_v_q  <= pend_v_d;
      pend_pc_q <= pend_pc_d;
    end
  end
`endif

endmodule
